// File: rtl/alu_seq_decoder.sv
// Sequenced ALU decoder: decodes {ALUOp, Funct} and holds ALUControl/SrcA and
// lane enables for the full multi-cycle duration of MUL and CONV operations.
module alu_seq_decoder #(
    parameter int LANES      = 4,
    parameter int MUL_CYCLES = 2,
    parameter int CONV_TAPS  = 9,
    parameter int TAP_W      = $clog2(CONV_TAPS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ALUOp,
    input  logic [3:0]       Funct,
    input  logic [LANES-1:0] lane_mask,
    input  logic             flush,
    output logic [2:0]       ALUControl,
    output logic             SrcA,
    output logic [LANES-1:0] lane_en,
    output logic [TAP_W-1:0] tap_idx,
    output logic             acc_clear,
    output logic             acc_en,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0]    MUL_PRE_LAST = CW'(MUL_CYCLES - 2);
    localparam logic [TAP_W-1:0] TAP_PRE_LAST = TAP_W'(CONV_TAPS - 2);

    typedef enum logic [1:0] {IDLE, EXEC1, MULT, CONV} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    state_t     dec_state;
    logic [2:0] dec_ctrl;
    logic       dec_srca;
    logic       dec_illegal;
    logic       accept;

    always_comb begin
        dec_state   = EXEC1;
        dec_ctrl    = 3'b111;
        dec_srca    = 1'b0;
        dec_illegal = 1'b0;
        if (ALUOp) begin
            if (Funct == 4'b1010) begin
                dec_ctrl = 3'b000;
                dec_srca = 1'b1;
            end else begin
                case (Funct[2:0])
                    3'b000: dec_ctrl = 3'b000;
                    3'b001: dec_ctrl = 3'b011;
                    3'b011: begin
                        dec_ctrl  = 3'b100;
                        dec_state = MULT;
                    end
                    3'b100: begin
                        dec_ctrl  = 3'b101;
                        dec_state = CONV;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
        end
    end

    // A flush on an active op blocks acceptance; flush while idle is a no-op.
    assign in_ready = !reset && !(flush && busy) && ((state == IDLE) || done);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (accept) begin
            state      <= dec_state;
            ALUControl <= dec_ctrl;
            SrcA       <= dec_srca;
            lane_en    <= lane_mask;
            tap_idx    <= '0;
            cnt        <= '0;
            busy       <= 1'b1;
            illegal    <= dec_illegal;
            acc_en     <= (dec_state == CONV);
            acc_clear  <= (dec_state == CONV);
            done       <= (dec_state == EXEC1) || ((dec_state == MULT) && (MUL_CYCLES == 1));
        end else if (reset || (flush && busy) || (state == IDLE) || done) begin
            state      <= IDLE;
            ALUControl <= 3'b111;
            SrcA       <= 1'b0;
            lane_en    <= '0;
            tap_idx    <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            illegal    <= 1'b0;
            acc_en     <= 1'b0;
            acc_clear  <= 1'b0;
            done       <= 1'b0;
        end else begin
            illegal   <= 1'b0;
            acc_clear <= 1'b0;
            case (state)
                MULT: begin
                    cnt  <= cnt + 1'b1;
                    done <= (cnt == MUL_PRE_LAST);
                end
                CONV: begin
                    tap_idx <= tap_idx + 1'b1;
                    done    <= (tap_idx == TAP_PRE_LAST);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_decoder.sv
// Directed testbench for alu_seq_decoder (MUL_CYCLES=3, CONV_TAPS=9, LANES=4).
module tb_alu_seq_decoder;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       ALUOp;
    logic [3:0] Funct;
    logic [3:0] lane_mask;
    logic       flush;
    logic [2:0] ALUControl;
    logic       SrcA;
    logic [3:0] lane_en;
    logic [3:0] tap_idx;
    logic       acc_clear;
    logic       acc_en;
    logic       busy;
    logic       done;
    logic       illegal;

    int tests;
    int fails;

    alu_seq_decoder #(.LANES(4), .MUL_CYCLES(3), .CONV_TAPS(9)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .Funct(Funct), .lane_mask(lane_mask), .flush(flush),
        .ALUControl(ALUControl), .SrcA(SrcA), .lane_en(lane_en), .tap_idx(tap_idx),
        .acc_clear(acc_clear), .acc_en(acc_en), .busy(busy), .done(done),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic op, input logic [3:0] f, input logic [3:0] m);
        in_valid  = 1'b1;
        ALUOp     = op;
        Funct     = f;
        lane_mask = m;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ctrl"}, ALUControl, 3'b111);
        chk({tag, ".srca"}, SrcA, 1'b0);
        chk({tag, ".lane"}, lane_en, 4'b0000);
        chk({tag, ".tap"}, tap_idx, 4'd0);
        chk({tag, ".accen"}, acc_en, 1'b0);
        chk({tag, ".accclr"}, acc_clear, 1'b0);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".done"}, done, 1'b0);
        chk({tag, ".illegal"}, illegal, 1'b0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1; in_valid = 1'b0; ALUOp = 1'b0; Funct = 4'h0;
        lane_mask = 4'h0; flush = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        #1;
        chk_idle("reset");
        chk("reset.ready", in_ready, 1'b1);

        // ADD
        present(1'b1, 4'b0000, 4'b1111);
        cyc();
        in_valid = 1'b0;
        chk("add.ctrl", ALUControl, 3'b000);
        chk("add.srca", SrcA, 1'b0);
        chk("add.lane", lane_en, 4'b1111);
        chk("add.busy", busy, 1'b1);
        chk("add.done", done, 1'b1);
        cyc();
        chk_idle("add_after");

        // MOV then ADD back-to-back
        present(1'b1, 4'b1010, 4'b0011);
        cyc();
        chk("mov.ctrl", ALUControl, 3'b000);
        chk("mov.srca", SrcA, 1'b1);
        chk("mov.done", done, 1'b1);
        chk("mov.lane", lane_en, 4'b0011);
        present(1'b1, 4'b0000, 4'b1100);
        #1;
        chk("mov.ready", in_ready, 1'b1);
        cyc();
        in_valid = 1'b0;
        chk("b2b_add.ctrl", ALUControl, 3'b000);
        chk("b2b_add.srca", SrcA, 1'b0);
        chk("b2b_add.done", done, 1'b1);
        chk("b2b_add.lane", lane_en, 4'b1100);
        cyc();
        chk_idle("b2b_after");

        // CONV, mask 0101
        present(1'b1, 4'b0100, 4'b0101);
        cyc();
        in_valid = 1'b0;
        for (int t = 0; t < 9; t++) begin
            chk($sformatf("conv%0d.ctrl", t), ALUControl, 3'b101);
            chk($sformatf("conv%0d.accen", t), acc_en, 1'b1);
            chk($sformatf("conv%0d.accclr", t), acc_clear, (t == 0) ? 1'b1 : 1'b0);
            chk($sformatf("conv%0d.tap", t), tap_idx, t);
            chk($sformatf("conv%0d.done", t), done, (t == 8) ? 1'b1 : 1'b0);
            chk($sformatf("conv%0d.lane", t), lane_en, 4'b0101);
            chk($sformatf("conv%0d.busy", t), busy, 1'b1);
            cyc();
        end
        chk_idle("conv_after");

        // MUL with in_valid held high (ADD queued behind it)
        present(1'b1, 4'b0011, 4'b1010);
        cyc();
        present(1'b1, 4'b1000, 4'b0110);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("mul%0d.ctrl", k), ALUControl, 3'b100);
            chk($sformatf("mul%0d.busy", k), busy, 1'b1);
            chk($sformatf("mul%0d.lane", k), lane_en, 4'b1010);
            chk($sformatf("mul%0d.done", k), done, (k == 2) ? 1'b1 : 1'b0);
            chk($sformatf("mul%0d.ready", k), in_ready, (k == 2) ? 1'b1 : 1'b0);
            cyc();
        end
        in_valid = 1'b0;
        chk("mul_next.ctrl", ALUControl, 3'b000);
        chk("mul_next.done", done, 1'b1);
        chk("mul_next.lane", lane_en, 4'b0110);
        cyc();
        chk_idle("mul_after");

        // Illegal DP op, then non-DP op
        present(1'b1, 4'b0111, 4'b1111);
        cyc();
        in_valid = 1'b0;
        chk("ill.ctrl", ALUControl, 3'b111);
        chk("ill.illegal", illegal, 1'b1);
        chk("ill.done", done, 1'b1);
        chk("ill.busy", busy, 1'b1);
        cyc();
        chk("ill_after.illegal", illegal, 1'b0);
        present(1'b0, 4'b0011, 4'b0001);
        cyc();
        in_valid = 1'b0;
        chk("nondp.ctrl", ALUControl, 3'b111);
        chk("nondp.illegal", illegal, 1'b0);
        chk("nondp.done", done, 1'b1);
        chk("nondp.busy", busy, 1'b1);
        cyc();

        // Zero lane mask SUB
        present(1'b1, 4'b0001, 4'b0000);
        cyc();
        in_valid = 1'b0;
        chk("sub0.ctrl", ALUControl, 3'b011);
        chk("sub0.lane", lane_en, 4'b0000);
        chk("sub0.done", done, 1'b1);
        cyc();

        // CONV flushed at tap 4
        present(1'b1, 4'b1100, 4'b1111);
        cyc();
        in_valid = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        chk("flush.tap4", tap_idx, 4'd4);
        flush = 1'b1;
        present(1'b1, 4'b0000, 4'b1111);
        #1;
        chk("flush.ready", in_ready, 1'b0);
        cyc();
        chk_idle("flush_after");
        flush = 1'b0;
        in_valid = 1'b0;
        cyc();
        chk_idle("flush_after2");

        // CONV reset at tap 4
        present(1'b1, 4'b0100, 4'b0011);
        cyc();
        in_valid = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        chk("rst.tap4", tap_idx, 4'd4);
        reset = 1'b1;
        #1;
        chk("rst.ready", in_ready, 1'b0);
        cyc();
        chk_idle("rst_after");
        reset = 1'b0;
        #1;
        chk("rst_after.ready", in_ready, 1'b1);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_seq_decoder.md
Name: alu_seq_decoder

Overview:
- Parametrised, sequenced successor to the single-cycle ALU decoder in the Filter-GPU control unit.
- Decodes {ALUOp, Funct} and holds ALUControl/SrcA for the full execution time of an operation:
  - ADD, SUB, MOV and non-DP execute in 1 cycle.
  - MUL executes in MUL_CYCLES cycles.
  - CONV executes in CONV_TAPS cycles, stepping a tap index and driving accumulator controls.
- Sits between the main decoder and the vector datapath. Provides a valid/ready handshake and per-lane enables.

Parameters:
- LANES, 4, number of vector lanes; width of lane_mask and lane_en.
- MUL_CYCLES, 2, cycles a MUL occupies; minimum 1.
- CONV_TAPS, 9, kernel taps per CONV; minimum 2.
- TAP_W, $clog2(CONV_TAPS), width of tap_idx.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation this cycle.
- ALUOp  in  1  1 = data-processing instruction.
- Funct  in  4  operation select.
- lane_mask  in  LANES  lanes active for this operation.
- flush  in  1  abort the current operation.
- ALUControl  out  3  datapath ALU function.
- SrcA  out  1  ALU A-operand select (1 = MOV path).
- lane_en  out  LANES  latched lane_mask while an op is active; 0 otherwise.
- tap_idx  out  TAP_W  current CONV tap.
- acc_clear  out  1  clear convolution accumulator.
- acc_en  out  1  accumulate this cycle.
- busy  out  1  an operation is executing.
- done  out  1  one-cycle pulse on the final cycle of an operation.
- illegal  out  1  one-cycle pulse: accepted DP op has an unsupported Funct.

Behaviour:
- Decode table, {ALUControl, SrcA}. An X means the bit is ignored.
  - ALUOp=0: 111,0; non-DP, 1 cycle.
  - ALUOp=1, Funct=X000: 000,0; ADD, 1 cycle.
  - ALUOp=1, Funct=X001: 011,0; SUB, 1 cycle.
  - ALUOp=1, Funct=X011: 100,0; MUL, MUL_CYCLES cycles.
  - ALUOp=1, Funct=X100: 101,0; CONV, CONV_TAPS cycles.
  - ALUOp=1, Funct=1010: 000,1; MOV, 1 cycle.
  - Any other Funct with ALUOp=1: output 111,0, pulse illegal, 1 cycle.
- States and transitions:
  - IDLE: wait for an operation.
  - EXEC1: single-cycle operation.
  - MULT: counter runs 0..MUL_CYCLES-1.
  - CONV: tap_idx runs 0..CONV_TAPS-1.
  - Accept (in_valid && in_ready) latches the decode and lane_mask. The next edge enters the op state. Outputs are registered, so there is 1 cycle of latency from accept to the first execute cycle.
- busy=1 in every non-IDLE state.
- done=1 on the final cycle of each state:
  - EXEC1: its only cycle.
  - MULT: count = MUL_CYCLES-1.
  - CONV: tap_idx = CONV_TAPS-1.
  - When MUL_CYCLES=1, MULT behaves exactly like EXEC1.
- in_ready = !reset && (state==IDLE || done). Accepting during a done cycle allows back-to-back issue with zero bubbles.
- On done with no accept, the block returns to IDLE: ALUControl=111, SrcA=0, lane_en=0, tap_idx=0.
- CONV cycles:
  - acc_en=1 on every CONV cycle.
  - acc_clear=1 only on tap 0.
  - tap_idx increments by 1 per cycle and never wraps inside an op.
- In non-CONV states: acc_en=0, acc_clear=0, tap_idx=0.
- illegal pulses during the EXEC1 cycle of an illegal op, together with done.
- flush:
  - Next edge goes to IDLE with no done, and all outputs return to reset values.
  - in_ready=0 in the flush cycle, so no new op is accepted.
  - flush in IDLE has no effect.
- reset (including mid-operation) forces, at the next edge: IDLE, ALUControl=111, SrcA=0, lane_en=0, tap_idx=0, acc_clear=0, acc_en=0, busy=0, done=0, illegal=0.
- in_valid is ignored while in_ready=0; inputs are not sampled until ready.
- A lane_mask of all zeros is legal: the op is sequenced normally with lane_en=0.

Test Plan:
- Reset, then ADD (ALUOp=1, Funct=0000, mask=1111) -> next cycle ALUControl=000, SrcA=0, lane_en=1111, busy=1, done=1; following cycle IDLE with ALUControl=111.
- MOV (Funct=1010) followed by ADD presented on MOV's done cycle -> 000/1 then 000/0 on consecutive cycles, done high both cycles, no bubble.
- CONV with defaults, mask=0101 -> 9 cycles of ALUControl=101 and acc_en=1, tap_idx 0..8; acc_clear only at tap 0; done only at tap 8; lane_en=0101 throughout.
- MUL with MUL_CYCLES=3 -> 3 cycles of ALUControl=100 with busy=1; in_ready=0 in the first two cycles (in_valid held high is not accepted); done and in_ready=1 in the third.
- Funct=0111 with ALUOp=1 -> one cycle of ALUControl=111, illegal=1, done=1. ALUOp=0 with any Funct -> 111, illegal=0.
- CONV interrupted by flush at tap 4 -> IDLE next cycle, no done, acc_en=0. Repeat with reset at tap 4 -> all outputs at reset values next cycle, in_ready=1 after reset deasserts.
